// File: rtl/eth_rx_frame_ctrl.sv
// eth_rx_frame_ctrl: serial RX framing controller.
// Finds preamble/SFD, deserialises LSB-first bytes and classifies each frame.
module eth_rx_frame_ctrl #(
   parameter int MIN_PREAMBLE_BITS = 16,
   parameter int MIN_FRAME_BYTES   = 64,
   parameter int MAX_FRAME_BYTES   = 1518,
   parameter int LEN_W             = 11
) (
   input  logic             rx_clk,
   input  logic             rst,
   input  logic             rx_dv,
   input  logic             serial_in,
   output logic [7:0]       byte_out,
   output logic             byte_valid,
   output logic             sof,
   output logic             eof,
   output logic             frame_ok,
   output logic [1:0]       err_code,
   output logic [LEN_W-1:0] frame_len,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE,
      PREAMBLE,
      DATA,
      DROP
   } state_t;

   localparam logic [7:0]       MIN_PRE = 8'(MIN_PREAMBLE_BITS);
   localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(MIN_FRAME_BYTES);
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_FRAME_BYTES);

   state_t           state_q;
   logic             armed_q;
   logic             prev_q;
   logic             started_q;
   logic             ovf_q;
   logic [7:0]       pre_cnt_q;
   logic [6:0]       shreg_q;
   logic [2:0]       bit_cnt_q;
   logic [LEN_W-1:0] byte_cnt_q;

   logic [7:0]       byte_out_q;
   logic             byte_valid_q;
   logic             sof_q;
   logic             eof_q;
   logic             frame_ok_q;
   logic [1:0]       err_code_q;
   logic [LEN_W-1:0] frame_len_q;

   logic [7:0]       new_byte;
   logic [1:0]       end_err;

   // Byte completed by the current bit and error class of a frame ending now.
   always_comb begin
      new_byte = {serial_in, shreg_q};
      end_err  = 2'd0;
      if (bit_cnt_q != 3'd0) begin
         end_err = 2'd3;
      end else if (byte_cnt_q < MIN_LEN) begin
         end_err = 2'd1;
      end
   end

   // Framing FSM with registered strobes and frame status.
   always_ff @(posedge rx_clk) begin
      if (rst) begin
         state_q      <= IDLE;
         armed_q      <= 1'b0;
         prev_q       <= 1'b0;
         started_q    <= 1'b0;
         ovf_q        <= 1'b0;
         pre_cnt_q    <= '0;
         shreg_q      <= '0;
         bit_cnt_q    <= '0;
         byte_cnt_q   <= '0;
         byte_out_q   <= '0;
         byte_valid_q <= 1'b0;
         sof_q        <= 1'b0;
         eof_q        <= 1'b0;
         frame_ok_q   <= 1'b0;
         err_code_q   <= '0;
         frame_len_q  <= '0;
      end else begin
         byte_valid_q <= 1'b0;
         sof_q        <= 1'b0;
         eof_q        <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (!rx_dv) begin
                  armed_q <= 1'b1;
               end else if (armed_q && serial_in) begin
                  state_q   <= PREAMBLE;
                  pre_cnt_q <= 8'd1;
                  prev_q    <= 1'b1;
               end
            end
            PREAMBLE: begin
               if (!rx_dv) begin
                  state_q <= IDLE;
                  armed_q <= 1'b1;
               end else if (serial_in != prev_q) begin
                  prev_q <= serial_in;
                  if (pre_cnt_q != 8'hFF) begin
                     pre_cnt_q <= pre_cnt_q + 8'd1;
                  end
               end else if (serial_in && (pre_cnt_q >= MIN_PRE)) begin
                  state_q    <= DATA;
                  bit_cnt_q  <= '0;
                  byte_cnt_q <= '0;
                  started_q  <= 1'b0;
                  ovf_q      <= 1'b0;
               end else begin
                  state_q   <= DROP;
                  started_q <= 1'b0;
                  ovf_q     <= 1'b0;
               end
            end
            DATA: begin
               if (!rx_dv) begin
                  eof_q       <= 1'b1;
                  frame_len_q <= byte_cnt_q;
                  err_code_q  <= end_err;
                  frame_ok_q  <= (end_err == 2'd0);
                  state_q     <= IDLE;
                  armed_q     <= 1'b1;
               end else begin
                  shreg_q   <= new_byte[7:1];
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     if (byte_cnt_q == MAX_LEN) begin
                        state_q <= DROP;
                        ovf_q   <= 1'b1;
                     end else begin
                        byte_out_q   <= new_byte;
                        byte_valid_q <= 1'b1;
                        sof_q        <= ~started_q;
                        started_q    <= 1'b1;
                        byte_cnt_q   <= byte_cnt_q + 1'b1;
                     end
                  end
               end
            end
            DROP: begin
               if (!rx_dv) begin
                  state_q <= IDLE;
                  armed_q <= 1'b1;
                  if (ovf_q) begin
                     eof_q       <= 1'b1;
                     err_code_q  <= 2'd2;
                     frame_ok_q  <= 1'b0;
                     frame_len_q <= MAX_LEN;
                     ovf_q       <= 1'b0;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign byte_out   = byte_out_q;
   assign byte_valid = byte_valid_q;
   assign sof        = sof_q;
   assign eof        = eof_q;
   assign frame_ok   = frame_ok_q;
   assign err_code   = err_code_q;
   assign frame_len  = frame_len_q;
   assign busy       = (state_q != IDLE);

endmodule
